// File: rtl/rgb2gray_stream.sv
`default_nettype none
// ============================================================================
//  Module   : rgb2gray_stream
//  Purpose  : Streaming RGB-to-gray converter. A three-stage pipeline forms a
//             weighted sum of the R, G and B channels, rounds it, rescales it
//             and saturates it. The coefficients are a preset (BT.601, BT.709
//             or equal weight) or a custom set. Valid/ready handshake on both
//             sides. One global stall enable freezes every stage together.
//  Ports    : clk, rst (async, active-high)
//             in_valid/in_ready/in_rgb{R,G,B}/in_user  - pixel input stream
//             mode, cfg_coef{KR,KG,KB}                 - coefficient select
//             out_valid/out_ready/out_gray/out_user    - gray output stream
//  Revision : 1.0 - initial release
// ============================================================================
module rgb2gray_stream #(
   parameter int DW     = 8,
   parameter int COEF_W = 8,
   parameter int USER_W = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [3*DW-1:0]     in_rgb,
   input  logic [USER_W-1:0]   in_user,
   input  logic [1:0]          mode,
   input  logic [3*COEF_W-1:0] cfg_coef,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DW-1:0]       out_gray,
   output logic [USER_W-1:0]   out_user
);

   localparam int c_prod_w = DW + COEF_W;
   localparam int c_sum_w  = DW + COEF_W + 2;
   localparam int c_quot_w = c_sum_w - COEF_W;
   localparam int c_shift  = COEF_W - 8;

   // Each preset set sums to 2^COEF_W. A preset result therefore never
   // exceeds the full-scale value.
   localparam logic [COEF_W-1:0] c_bt601_kr = COEF_W'(77)  << c_shift;
   localparam logic [COEF_W-1:0] c_bt601_kg = COEF_W'(150) << c_shift;
   localparam logic [COEF_W-1:0] c_bt601_kb = COEF_W'(29)  << c_shift;
   localparam logic [COEF_W-1:0] c_bt709_kr = COEF_W'(54)  << c_shift;
   localparam logic [COEF_W-1:0] c_bt709_kg = COEF_W'(183) << c_shift;
   localparam logic [COEF_W-1:0] c_bt709_kb = COEF_W'(19)  << c_shift;
   localparam logic [COEF_W-1:0] c_eq_kr    = COEF_W'(85)  << c_shift;
   localparam logic [COEF_W-1:0] c_eq_kg    = COEF_W'(86)  << c_shift;
   localparam logic [COEF_W-1:0] c_eq_kb    = COEF_W'(85)  << c_shift;
   localparam logic [c_sum_w-1:0] c_round   = c_sum_w'(1) << (COEF_W - 1);

   logic                w_en;
   logic [DW-1:0]       w_r, w_g, w_b;
   logic [COEF_W-1:0]   w_kr, w_kg, w_kb;
   logic [c_quot_w-1:0] w_quot;

   logic                s1_valid_d, s1_valid_q;
   logic [USER_W-1:0]   s1_user_d,  s1_user_q;
   logic [c_prod_w-1:0] s1_pr_d, s1_pr_q, s1_pg_d, s1_pg_q, s1_pb_d, s1_pb_q;
   logic                s2_valid_d, s2_valid_q;
   logic [USER_W-1:0]   s2_user_d,  s2_user_q;
   logic [c_sum_w-1:0]  s2_sum_d,   s2_sum_q;
   logic                s3_valid_d, s3_valid_q;
   logic [USER_W-1:0]   s3_user_d,  s3_user_q;
   logic [DW-1:0]       s3_gray_d,  s3_gray_q;

   // The output register is either empty or draining, so the whole pipe may
   // advance. This enable also acts as the input ready signal.
   assign w_en     = ~s3_valid_q | out_ready;
   assign in_ready = w_en;

   assign w_r = in_rgb[3*DW-1:2*DW];
   assign w_g = in_rgb[2*DW-1:DW];
   assign w_b = in_rgb[DW-1:0];

   // The coefficients are chosen in the accept cycle and consumed at once by
   // stage 1. A later mode change cannot reach a pixel already in flight.
   always_comb begin
      w_kr = c_bt601_kr;
      w_kg = c_bt601_kg;
      w_kb = c_bt601_kb;
      case (mode)
         2'd0: begin
            w_kr = c_bt601_kr;
            w_kg = c_bt601_kg;
            w_kb = c_bt601_kb;
         end
         2'd1: begin
            w_kr = c_bt709_kr;
            w_kg = c_bt709_kg;
            w_kb = c_bt709_kb;
         end
         2'd2: begin
            w_kr = c_eq_kr;
            w_kg = c_eq_kg;
            w_kb = c_eq_kb;
         end
         default: begin
            w_kr = cfg_coef[3*COEF_W-1:2*COEF_W];
            w_kg = cfg_coef[2*COEF_W-1:COEF_W];
            w_kb = cfg_coef[COEF_W-1:0];
         end
      endcase
   end

   // Drop the fractional bits. The quotient keeps two guard bits, so an
   // overflow is detected and clamped rather than wrapped.
   assign w_quot = s2_sum_q[c_sum_w-1:COEF_W];

   always_comb begin
      s1_valid_d = in_valid;
      s1_user_d  = in_user;
      s1_pr_d    = c_prod_w'(w_r) * c_prod_w'(w_kr);
      s1_pg_d    = c_prod_w'(w_g) * c_prod_w'(w_kg);
      s1_pb_d    = c_prod_w'(w_b) * c_prod_w'(w_kb);

      s2_valid_d = s1_valid_q;
      s2_user_d  = s1_user_q;
      s2_sum_d   = c_sum_w'(s1_pr_q) + c_sum_w'(s1_pg_q) + c_sum_w'(s1_pb_q) + c_round;

      s3_valid_d = s2_valid_q;
      s3_user_d  = s2_user_q;
      s3_gray_d  = (|w_quot[c_quot_w-1:DW]) ? {DW{1'b1}} : w_quot[DW-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_user_q  <= '0;
         s1_pr_q    <= '0;
         s1_pg_q    <= '0;
         s1_pb_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_user_q  <= '0;
         s2_sum_q   <= '0;
         s3_valid_q <= 1'b0;
         s3_user_q  <= '0;
         s3_gray_q  <= '0;
      end else if (w_en) begin
         s1_valid_q <= s1_valid_d;
         s1_user_q  <= s1_user_d;
         s1_pr_q    <= s1_pr_d;
         s1_pg_q    <= s1_pg_d;
         s1_pb_q    <= s1_pb_d;
         s2_valid_q <= s2_valid_d;
         s2_user_q  <= s2_user_d;
         s2_sum_q   <= s2_sum_d;
         s3_valid_q <= s3_valid_d;
         s3_user_q  <= s3_user_d;
         s3_gray_q  <= s3_gray_d;
      end
   end

   assign out_valid = s3_valid_q;
   assign out_gray  = s3_gray_q;
   assign out_user  = s3_user_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb2gray_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rgb2gray_stream
//  Purpose  : Self-checking bench for rgb2gray_stream. It runs directed
//             vectors, a mode switch, a randomized stream with backpressure,
//             and a reset applied mid-stream. The expected values come from a
//             plain-arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rgb2gray_stream;

   localparam int DW     = 8;
   localparam int COEF_W = 8;
   localparam int USER_W = 5;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [3*DW-1:0]     in_rgb;
   logic [USER_W-1:0]   in_user;
   logic [1:0]          mode;
   logic [3*COEF_W-1:0] cfg_coef;
   logic                out_valid;
   logic                out_ready;
   logic [DW-1:0]       out_gray;
   logic [USER_W-1:0]   out_user;

   int n_tests = 0;
   int n_fail  = 0;

   rgb2gray_stream #(.DW(DW), .COEF_W(COEF_W), .USER_W(USER_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_rgb    (in_rgb),
      .in_user   (in_user),
      .mode      (mode),
      .cfg_coef  (cfg_coef),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_gray  (out_gray),
      .out_user  (out_user)
   );

   always #5 clk = ~clk;

   // Reference: a rounded weighted average with a clamp to full scale.
   function automatic int unsigned model_gray(input logic [23:0] rgb, input logic [1:0] m,
                                              input logic [23:0] coef);
      int unsigned r, g, b, kr, kg, kb, s;
      r = rgb[23:16]; g = rgb[15:8]; b = rgb[7:0];
      case (m)
         2'd0:    begin kr = 77; kg = 150; kb = 29; end
         2'd1:    begin kr = 54; kg = 183; kb = 19; end
         2'd2:    begin kr = 85; kg = 86;  kb = 85; end
         default: begin kr = coef[23:16]; kg = coef[15:8]; kb = coef[7:0]; end
      endcase
      s = (r * kr + g * kg + b * kb + 128) / 256;
      if (s > 255) s = 255;
      return s;
   endfunction

   // Presents one pixel to an empty pipe and waits for its result. The
   // inputs are scrambled after acceptance. lat counts clock edges, with the
   // acceptance edge counted as 1. A value of 99 means no result appeared.
   task automatic push_one(input logic [23:0] rgb, input logic [1:0] m, input logic [23:0] coef,
                           input logic [4:0] u, output int lat, output logic [7:0] g,
                           output logic [4:0] gu);
      in_rgb = rgb; mode = m; cfg_coef = coef; in_user = u;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_rgb = $urandom; mode = 2'($urandom); cfg_coef = $urandom;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      if (out_valid !== 1'b1) lat = 99;
      g = out_gray; gu = out_user;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_rgb = '0; in_user = '0; mode = 2'd0; cfg_coef = '0;
      #12;
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_tests++;
      if (out_gray !== 8'd0) begin n_fail++; $display("FAIL reset_out_gray got=%0d exp=0", out_gray); end
      n_tests++;
      if (out_user !== 5'd0) begin n_fail++; $display("FAIL reset_out_user got=%0d exp=0", out_user); end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [23:0] t_rgb  [8];
      logic [1:0]  t_mode [8];
      logic [23:0] t_coef [8];
      logic [7:0]  t_exp  [8];
      int          lat;
      logic [7:0]  g;
      logic [4:0]  gu;
      t_rgb  = '{24'h6432C8, 24'h00FF00, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
                 24'h000000, 24'h000000, 24'h000000};
      t_mode = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3};
      t_coef = '{24'h0, 24'h0, 24'h0, 24'h0, 24'hFFFFFF, 24'h0, 24'h0, 24'hA5C3F1};
      t_exp  = '{8'd82, 8'd182, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0};
      for (int i = 0; i < 8; i++) begin
         push_one(t_rgb[i], t_mode[i], t_coef[i], 5'(i + 3), lat, g, gu);
         n_tests++;
         if (g !== t_exp[i]) begin n_fail++; $display("FAIL directed_gray[%0d] got=%0d exp=%0d", i, g, t_exp[i]); end
         n_tests++;
         if (lat !== 3) begin n_fail++; $display("FAIL directed_latency[%0d] got=%0d exp=3", i, lat); end
         n_tests++;
         if (gu !== 5'(i + 3)) begin n_fail++; $display("FAIL directed_user[%0d] got=%0d exp=%0d", i, gu, i + 3); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_mode_switch();
      logic [7:0] got_g [$];
      logic [4:0] got_u [$];
      out_ready = 1'b1;
      in_valid = 1'b1; in_rgb = 24'h00FF00; mode = 2'd0; in_user = 5'd1;
      @(posedge clk); #1;
      mode = 2'd1; in_user = 5'd2;
      @(posedge clk); #1;
      in_valid = 1'b0; mode = 2'd2; in_rgb = $urandom; cfg_coef = $urandom;
      for (int c = 0; c < 10; c++) begin
         if (out_valid === 1'b1) begin got_g.push_back(out_gray); got_u.push_back(out_user); end
         @(posedge clk); #1;
      end
      n_tests++;
      if (got_g.size() !== 2) begin
         n_fail++; $display("FAIL mode_switch_count got=%0d exp=2", got_g.size());
      end else begin
         n_tests++;
         if (got_g[0] !== 8'd149) begin n_fail++; $display("FAIL mode_switch_first got=%0d exp=149", got_g[0]); end
         n_tests++;
         if (got_g[1] !== 8'd182) begin n_fail++; $display("FAIL mode_switch_second got=%0d exp=182", got_g[1]); end
         n_tests++;
         if (got_u[0] !== 5'd1 || got_u[1] !== 5'd2) begin
            n_fail++; $display("FAIL mode_switch_user got=%0d,%0d exp=1,2", got_u[0], got_u[1]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] px_rgb [16];
      logic [1:0]  px_m   [16];
      logic [23:0] px_c   [16];
      logic [7:0]  exp_g [$];
      logic [4:0]  exp_u [$];
      int          sent, got, cyc;
      logic        prev_stall;
      logic [7:0]  prev_g;
      logic [4:0]  prev_u;
      for (int i = 0; i < 16; i++) begin
         px_rgb[i] = $urandom; px_m[i] = 2'($urandom); px_c[i] = $urandom;
      end
      sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_g = '0; prev_u = '0;
      while (got < 16 && cyc < 300) begin
         // A fixed 5-cycle stall window, plus occasional random backpressure.
         if (cyc >= 6 && cyc < 11) out_ready = 1'b0;
         else                      out_ready = ($urandom_range(0, 4) != 0);
         if (sent < 16) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_rgb = px_rgb[sent]; mode = px_m[sent]; cfg_coef = px_c[sent]; in_user = 5'(sent + 8);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (prev_stall) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_gray !== prev_g || out_user !== prev_u) begin
               n_fail++;
               $display("FAIL stall_hold got=%b/%0d/%0d exp=1/%0d/%0d", out_valid, out_gray, out_user, prev_g, prev_u);
            end
         end
         if (cyc >= 6 && cyc < 11 && out_valid === 1'b1) begin
            n_tests++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_tests++;
            if (exp_g.size() == 0) begin
               n_fail++; $display("FAIL stream_spurious got=%0d exp=none", out_gray);
            end else if (out_gray !== exp_g[0] || out_user !== exp_u[0]) begin
               n_fail++;
               $display("FAIL stream_data[%0d] got=%0d/%0d exp=%0d/%0d", got, out_gray, out_user, exp_g[0], exp_u[0]);
            end
            if (exp_g.size() != 0) begin void'(exp_g.pop_front()); void'(exp_u.pop_front()); end
            got++;
         end
         if (in_valid === 1'b1 && in_ready === 1'b1) begin
            exp_g.push_back(8'(model_gray(px_rgb[sent], px_m[sent], px_c[sent])));
            exp_u.push_back(5'(sent + 8));
            sent++;
         end
         prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
         prev_g = out_gray; prev_u = out_user;
         @(posedge clk); #1;
         cyc++;
      end
      n_tests++;
      if (got !== 16) begin n_fail++; $display("FAIL stream_count got=%0d exp=16", got); end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_midstream();
      logic [23:0] rgb;
      int          lat;
      logic [7:0]  g;
      logic [4:0]  gu;
      int          seen;
      out_ready = 1'b1; mode = 2'd0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_rgb = $urandom | 24'h808080; in_user = 5'(20 + i);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
      n_tests++;
      if (out_gray !== 8'd0 || out_user !== 5'd0) begin
         n_fail++; $display("FAIL midrst_out_data got=%0d/%0d exp=0/0", out_gray, out_user);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) seen++;
      end
      n_tests++;
      if (seen !== 0) begin n_fail++; $display("FAIL midrst_flushed got=%0d valid cycles exp=0", seen); end
      rgb = $urandom;
      push_one(rgb, 2'd1, 24'h0, 5'd26, lat, g, gu);
      n_tests++;
      if (g !== 8'(model_gray(rgb, 2'd1, 24'h0))) begin
         n_fail++; $display("FAIL midrst_next_gray got=%0d exp=%0d", g, model_gray(rgb, 2'd1, 24'h0));
      end
      n_tests++;
      if (lat !== 3) begin n_fail++; $display("FAIL midrst_next_latency got=%0d exp=3", lat); end
      n_tests++;
      if (gu !== 5'd26) begin n_fail++; $display("FAIL midrst_next_user got=%0d exp=26", gu); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_mode_switch();
      test_back_to_back();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rgb2gray_stream.md
RGB2GRAY_STREAM -- requirements
Module: rgb2gray_stream

Interface
- REQ-001 Parameter DW, default 8: bits per colour channel and per gray output.
- REQ-002 Parameter COEF_W, default 8: coefficient width; the SHALL legal range is COEF_W >= 8.
- REQ-003 Parameter USER_W, default 3: width of the sideband passed through (e.g. {vs,hs,de}).
- REQ-004 Timing: one clock; reset is asynchronous and active-high.
- REQ-005 clk  in  1  sole clock; all state SHALL be on its rising edge.
- REQ-006 rst  in  1  asynchronous active-high reset.
- REQ-007 in_valid  in  1  input pixel valid.
- REQ-008 in_ready  out  1  block accepts a pixel when in_valid & in_ready.
- REQ-009 in_rgb  in  3*DW  {R,G,B}, R in the MSBs.
- REQ-010 in_user  in  USER_W  sideband, carried aligned with its pixel.
- REQ-011 mode  in  2  coefficient select: 0 BT.601, 1 BT.709, 2 equal-weight, 3 custom.
- REQ-012 cfg_coef  in  3*COEF_W  custom {KR,KG,KB}, used only when mode=3.
- REQ-013 out_valid  out  1  output gray valid.
- REQ-014 out_ready  in  1  downstream accept.
- REQ-015 out_gray  out  DW  gray result.
- REQ-016 out_user  out  USER_W  sideband of the pixel on out_gray.

Function
- REQ-017 Preset coefficients at COEF_W=8 SHALL be: mode0 (77,150,29), mode1 (54,183,19), mode2 (85,86,85); for COEF_W>8 they SHALL be left-shifted by COEF_W-8.
- REQ-018 The block SHALL sample mode and cfg_coef on the accepting cycle together with the pixel; later changes SHALL NOT affect pixels already in flight.
- REQ-019 Pipeline: S1 registers the three products (DW+COEF_W bits each); S2 registers the sum plus the rounding constant 2^(COEF_W-1) (DW+COEF_W+2 bits); S3 registers the sum >> COEF_W, saturated to 2^DW-1.
- REQ-020 Latency SHALL be exactly 3 clk from acceptance to out_valid when out_ready stays high; throughput SHALL be 1 pixel/clk.
- REQ-021 Each stage SHALL carry a valid bit and the USER_W sideband so that out_user always belongs to out_gray.
- REQ-022 Global stall: en = ~out_valid | out_ready; in_ready = en; all stages advance only when en=1.
- REQ-023 While out_valid=1 and out_ready=0, out_gray, out_user and out_valid SHALL hold stable, and no pixel SHALL be lost or duplicated.
- REQ-024 Bubbles (invalid stage slots) MAY propagate; out_valid SHALL NOT assert for a bubble.
- REQ-025 in_valid=1 with in_ready=0 SHALL NOT be accepted; the source holds its data.
- REQ-026 Saturation is reachable only in mode 3 (preset sums equal 2^COEF_W); the result SHALL clamp and SHALL NOT wrap.
- REQ-027 All-zero input SHALL yield 0 in every mode.

Reset
- REQ-028 On rst, all stage valids, out_valid, out_gray and out_user SHALL clear to 0 asynchronously; in_ready SHALL be 1 while rst=0 and the pipe is empty.
- REQ-029 Reset asserted mid-stream SHALL discard all in-flight pixels; after release the first output SHALL be the first pixel accepted after release.
- REQ-030 Datapath registers SHALL also reset to 0, so that no X reaches out_gray.

Verification
- REQ-031 mode0, in_rgb=(100,50,200), out_ready=1 -> out_gray=82 exactly 3 clk later.
- REQ-032 mode1, (0,255,0) -> 182; mode0, (255,255,255) -> 255; mode2, (255,255,255) -> 255.
- REQ-033 mode3, cfg_coef=(255,255,255), in (255,255,255) -> 255 (saturated, not 250).
- REQ-034 Stream 16 pixels with a distinct in_user each; hold out_ready=0 for 5 clk mid-stream -> in_ready=0 during the stall, outputs held, all 16 arrive in order with matching out_user.
- REQ-035 Switch mode 0->1 on consecutive accepted pixels of (0,255,0) -> outputs 149 then 182.
- REQ-036 Assert rst for 1 clk with 3 pixels in flight -> out_valid=0 immediately, none of the 3 emerge, and the next accepted pixel emerges 3 clk after its acceptance.
